rr_burst_arbiter: RTL and testbench

//  Round-robin arbiter that time-shares one benchmark FSM datapath (s298-class

---
 rtl/rr_burst_arbiter.sv | 110 +++++++++++
 tb/tb_rr_burst_arbiter.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/rr_burst_arbiter.sv
// Round-robin arbiter with registered one-hot grants, burst limiting and a
// one-cycle turnaround gap between owners.
module rr_burst_arbiter #(
   parameter int N_REQ     = 4,
   parameter int ID_W      = 2,
   parameter int MAX_BURST = 8,
   parameter int BURST_W   = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_REQ-1:0]   req,
   input  logic [N_REQ-1:0]   last,
   output logic [N_REQ-1:0]   gnt,
   output logic               gnt_valid,
   output logic [ID_W-1:0]    gnt_id,
   output logic [BURST_W-1:0] burst_cnt,
   output logic               expire
);

   typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

   localparam logic [ID_W-1:0]    LAST_ID = ID_W'(N_REQ - 1);
   localparam logic [BURST_W-1:0] CNT_MAX = BURST_W'(MAX_BURST - 1);

   state_t               state, state_nxt;
   logic [ID_W-1:0]      ptr, ptr_nxt;
   logic [ID_W-1:0]      pick, cand;
   logic                 found;
   logic [N_REQ-1:0]     gnt_nxt;
   logic                 gnt_valid_nxt;
   logic [ID_W-1:0]      gnt_id_nxt;
   logic [BURST_W-1:0]   burst_nxt;
   logic                 own_req, own_last, at_max, burst_end;

   // First requester at or above ptr, wrapping modulo N_REQ.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      cand  = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         cand = ID_W'((32'(ptr) + i) % N_REQ);
         if (!found && req[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   assign own_req   = req[gnt_id];
   assign own_last  = last[gnt_id];
   assign at_max    = (burst_cnt == CNT_MAX);
   assign burst_end = ~own_req | own_last | at_max;
   assign expire    = (state == GRANT) & at_max & own_req & ~own_last;

   always_comb begin
      state_nxt     = state;
      ptr_nxt       = ptr;
      gnt_nxt       = gnt;
      gnt_valid_nxt = gnt_valid;
      gnt_id_nxt    = gnt_id;
      burst_nxt     = burst_cnt;
      case (state)
         IDLE, GAP: begin
            state_nxt     = IDLE;
            gnt_nxt       = '0;
            gnt_valid_nxt = 1'b0;
            gnt_id_nxt    = '0;
            burst_nxt     = '0;
            if (found) begin
               state_nxt     = GRANT;
               gnt_nxt       = N_REQ'(1) << pick;
               gnt_valid_nxt = 1'b1;
               gnt_id_nxt    = pick;
            end
         end
         GRANT: begin
            if (burst_end) begin
               state_nxt     = GAP;
               gnt_nxt       = '0;
               gnt_valid_nxt = 1'b0;
               gnt_id_nxt    = '0;
               burst_nxt     = '0;
               ptr_nxt       = (gnt_id == LAST_ID) ? '0 : gnt_id + 1'b1;
            end else begin
               burst_nxt = burst_cnt + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         ptr       <= '0;
         gnt       <= '0;
         gnt_valid <= 1'b0;
         gnt_id    <= '0;
         burst_cnt <= '0;
      end else begin
         state     <= state_nxt;
         ptr       <= ptr_nxt;
         gnt       <= gnt_nxt;
         gnt_valid <= gnt_valid_nxt;
         gnt_id    <= gnt_id_nxt;
         burst_cnt <= burst_nxt;
      end
   end

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Randomized and directed bench for rr_burst_arbiter against a
// transaction-level owner/pointer model.
module tb_rr_burst_arbiter;

   localparam int N   = 4;
   localparam int IDW = 2;
   localparam int MB  = 8;
   localparam int BW  = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req, last;
   logic [N-1:0]   gnt;
   logic           gnt_valid;
   logic [IDW-1:0] gnt_id;
   logic [BW-1:0]  burst_cnt;
   logic           expire;

   always #5 clk = ~clk;

   rr_burst_arbiter #(.N_REQ(N), .ID_W(IDW), .MAX_BURST(MB), .BURST_W(BW)) dut (
      .clk(clk), .rst(rst), .req(req), .last(last), .gnt(gnt),
      .gnt_valid(gnt_valid), .gnt_id(gnt_id), .burst_cnt(burst_cnt), .expire(expire)
   );

   int total = 0;
   int bad   = 0;

   // Model: owner is -1 when nobody holds the bus (idle and gap look alike).
   int m_owner = -1;
   int m_held  = 0;
   int m_ptr   = 0;
   int seq[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int pick_from(input logic [N-1:0] r, input int p);
      for (int k = 0; k < N; k++)
         if (r[(p + k) % N]) return (p + k) % N;
      return -1;
   endfunction

   function automatic logic m_expire(input logic [N-1:0] r, input logic [N-1:0] l);
      return (m_owner >= 0) && (m_held == MB - 1) && r[m_owner] && !l[m_owner];
   endfunction

   task automatic step(input logic r_rst, input logic [N-1:0] r_req, input logic [N-1:0] r_last);
      @(negedge clk);
      rst  = r_rst;
      req  = r_req;
      last = r_last;
      #1;
      check("expire", 32'(expire), 32'(m_expire(r_req, r_last)));
      @(posedge clk);
      if (r_rst) begin
         m_owner = -1; m_held = 0; m_ptr = 0;
      end else if (m_owner >= 0) begin
         if (!r_req[m_owner] || r_last[m_owner] || m_held == MB - 1) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
            m_held  = 0;
         end else begin
            m_held++;
         end
      end else begin
         m_owner = pick_from(r_req, m_ptr);
         m_held  = 0;
      end
      #1;
      check("gnt", 32'(gnt), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
      check("gnt_valid", 32'(gnt_valid), 32'(m_owner >= 0));
      check("gnt_id", 32'(gnt_id), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
      check("burst_cnt", 32'(burst_cnt), 32'(m_held));
      if (gnt_valid && burst_cnt == 0) seq.push_back(int'(gnt_id));
   endtask

   initial begin
      logic [N-1:0] r, l;
      int n_exp;
      rst = 1'b1; req = '0; last = '0;
      @(posedge clk);

      // 1: reset held with all requesting, then first grant to 0
      step(1'b1, 4'b1111, 4'b0000);
      step(1'b1, 4'b1111, 4'b0000);
      step(1'b0, 4'b1111, 4'b0000);
      check("t1_first_gnt", 32'(gnt), 32'h1);

      // 2: single owner releasing on its third cycle, then regranted
      step(1'b1, '0, '0);
      for (int c = 0; c < 8; c++) begin
         l = (m_owner == 2 && m_held == 2) ? 4'b0100 : 4'b0000;
         step(1'b0, 4'b0100, l);
      end

      // 3: rotation with last on every first cycle
      step(1'b1, '0, '0);
      seq.delete();
      for (int c = 0; c < 10; c++) begin
         l = (m_owner >= 0 && m_held == 0) ? 4'(1 << m_owner) : 4'b0000;
         step(1'b0, 4'b1111, l);
      end
      check("t3_count", 32'(seq.size()), 32'd5);
      for (int k = 0; k < 5 && k < seq.size(); k++)
         check("t3_order", 32'(seq[k]), 32'(k % N));

      // 4: truncation at MAX_BURST, then handover to 1
      step(1'b1, '0, '0);
      n_exp = 0;
      for (int c = 0; c < 12; c++) begin
         step(1'b0, 4'b0011, 4'b0000);
         if (c == 9) check("t4_next_owner", 32'(gnt), 32'h2);
      end

      // 5: owner 1 drops req on its second grant cycle
      step(1'b1, '0, '0);
      for (int c = 0; c < 6; c++) begin
         r = (m_owner == 1 && m_held == 1) ? 4'b0100 : 4'b0110;
         step(1'b0, r, 4'b0000);
      end
      check("t5_owner2", 32'(gnt), 32'h4);

      // 6: reset at burst_cnt 4, then search restarts from 0
      step(1'b1, '0, '0);
      while (!(m_owner == 1 && m_held == 4)) step(1'b0, 4'b0010, 4'b0000);
      step(1'b1, 4'b1000, 4'b0000);
      check("t6_cleared", 32'(gnt), 32'h0);
      step(1'b0, 4'b1000, 4'b0000);
      check("t6_regrant", 32'(gnt), 32'h8);
      step(1'b0, 4'b1000, 4'b0000);

      // random traffic
      for (int c = 0; c < 3000; c++) begin
         r = 4'($urandom);
         l = '0;
         for (int b = 0; b < N; b++) l[b] = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 3) == 0) r = 4'b1111;
         if ($urandom_range(0, 4) == 0) l = '0;
         step($urandom_range(0, 199) == 0, r, l);
         if (expire) n_exp++;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
